serial_subtractor: RTL and testbench
====================================

// Module: serial_subtractor
// PURPOSE
//   Bit-serial N-bit unsigned subtractor: D = A - B - BIN, LSB first, one bit per clock.
//   Inverse companion to the team's single-bit full-adder cell.
//   Used where area matters more than throughput.
//   Operands are accepted on a valid/ready handshake; the result is returned on a valid/ready handshake.
// PARAMETERS
//   WIDTH  8  operand/result width in bits; legal range >= 1
// PORTS
//   clk        in   1      single clock, rising edge
//   rst_n      in   1      asynchronous, active-low reset
//   in_valid   in   1      operands a, b, bin are valid
//   in_ready   out  1      block can accept operands
//   a          in   WIDTH  minuend
//   b          in   WIDTH  subtrahend
//   bin        in   1      borrow in
//   out_valid  out  1      d and bout are valid
//   out_ready  in   1      consumer accepts the result
//   d          out  WIDTH  difference
//   bout       out  1      borrow out (1 = underflow)
//   busy       out  1      high in RUN and DONE
// BEHAVIOUR
//   Reset (async, rst_n=0):
//     - state=IDLE; in_ready=1; out_valid=0; busy=0; d=0; bout=0; internal registers cleared.
//   FSM states: IDLE, RUN, DONE.
//   IDLE
//     - in_ready=1.
//     - On in_valid&&in_ready at edge k: load a->ra, b->rb, bin->borrow; cnt=0; go to RUN.
//   RUN (in_ready=0)
//     - Each cycle, full_subtractor(ra[0], rb[0], borrow) -> {diff, bo}.
//     - ra and rb shift right; diff shifts into rd at the MSB; borrow<=bo; cnt++.
//     - When cnt==WIDTH-1: go to DONE.
//   DONE
//     - out_valid=1; d=rd; bout=borrow; all held stable until out_ready.
//     - On out_valid&&out_ready: go to IDLE, out_valid=0.
//   Latency: out_valid rises after edge k+WIDTH (WIDTH RUN cycles).
//     - Result accepted the same cycle out_ready is seen.
//     - Next operand accepted no earlier than the following cycle.
//     - No overlap of operations; throughput is one result per WIDTH+2 cycles minimum.
//   Arithmetic
//     - d = (a - b - bin) mod 2^WIDTH.
//     - bout = 1 iff a < b + bin, evaluated unsigned with WIDTH+1-bit precision.
//   Boundaries
//     - in_valid outside IDLE: ignored; a, b, bin are don't-care.
//     - out_ready while not in DONE: no effect.
//     - out_ready held low: DONE held indefinitely; d and bout must not change.
//     - WIDTH=1: cnt is 1 bit; exactly one RUN cycle.
//     - rst_n low mid-RUN or mid-DONE: immediate return to reset values; partial result discarded.
//     - d and bout are registered only; no combinational path from input ports to outputs.
// CONFIGURATION
//   SERIAL_SUB_SAT_EN
//     - Defined: on entry to DONE with final borrow=1, d is forced to 0 (saturate at zero).
//       bout still reports 1.
//     - Undefined: d wraps modulo 2^WIDTH.
//     - Handshake and latency are identical in both builds.
// STRUCTURE
//   serial_arith_pkg
//     - typedef enum {IDLE, RUN, DONE} ser_state_t, with explicit 2-bit encoding.
//     - Function cnt_w(WIDTH) = max(1, $clog2(WIDTH)).
//   Sub-module full_subtractor (combinational, 1 bit)
//     - diff = x ^ y ^ bi.
//     - bo = (~x & y) | (~x & bi) | (y & bi).
//     - Instantiated once.
//   Top level: FSM, counter, ra/rb/rd shift registers, borrow flop.
// TESTING
//   T1 (WIDTH=8): a=8'h5A, b=8'h1C, bin=0.
//      -> d=8'h3E, bout=0; out_valid high exactly 8 cycles after the accept edge.
//   T2: a=8'h00, b=8'h01, bin=0.
//      -> d=8'hFF, bout=1; with SERIAL_SUB_SAT_EN: d=8'h00, bout=1.
//   T3: a=8'hFF, b=8'hFF, bin=1.
//      -> d=8'hFF, bout=1.
//   T4: out_ready low for 5 cycles in DONE.
//      -> out_valid, d and bout stable throughout.
//      -> in_ready=0 throughout; IDLE entered the cycle after out_ready=1.
//   T5: rst_n pulsed low at cnt=3 of a RUN.
//      -> all outputs at reset values asynchronously.
//      -> next op a=8'h10, b=8'h01 -> d=8'h0F.
//   T6: in_valid held high with new operands during RUN.
//      -> ignored; the first result is unchanged.
//      -> the new operands are accepted only after return to IDLE.

Source files
------------

// File: rtl/serial_arith_pkg.sv
// Shared types and helpers for the bit-serial arithmetic blocks.
// Holds the FSM state encoding and the counter-width rule.
package serial_arith_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } ser_state_t;

   // A 1-bit counter is still needed when WIDTH is 1 or 2.
   function automatic int cnt_w(input int width);
      int w;
      w = $clog2(width);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: diff = x - y - bi, borrow out on underflow.
// Purely combinational, no latency, no flow control.
module full_subtractor (
   input  logic i_x,
   input  logic i_y,
   input  logic i_bi,
   output logic o_diff,
   output logic o_bo
);

   assign o_diff = i_x ^ i_y ^ i_bi;
   assign o_bo   = (~i_x & i_y) | (~i_x & i_bi) | (i_y & i_bi);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor, LSB first; result valid WIDTH cycles after accept and held until out_ready.
// Optional SERIAL_SUB_SAT_EN clamps the difference to zero on underflow.
module serial_subtractor
   import serial_arith_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] d,
   output logic             bout,
   output logic             busy
);

   localparam int             CW       = cnt_w(WIDTH);
   localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

   ser_state_t       r_state;
   ser_state_t       w_next_state;
   logic [WIDTH-1:0] r_ra;
   logic [WIDTH-1:0] r_rb;
   logic [WIDTH-1:0] r_rd;
   logic [WIDTH-1:0] r_d;
   logic             r_bout;
   logic             r_borrow;
   logic [CW-1:0]    r_cnt;
   logic             w_diff;
   logic             w_bo;
   logic             w_last;
   logic [WIDTH:0]   w_rd_shift;
   logic [WIDTH-1:0] w_rd_next;

   full_subtractor u_fsub (
      .i_x    (r_ra[0]),
      .i_y    (r_rb[0]),
      .i_bi   (r_borrow),
      .o_diff (w_diff),
      .o_bo   (w_bo)
   );

   // New difference bit enters at the MSB so the LSB-first stream lands in order.
   assign w_rd_shift = {w_diff, r_rd};
   assign w_rd_next  = w_rd_shift[WIDTH:1];
   assign w_last     = (r_state == RUN) && (r_cnt == LAST_CNT);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      in_ready     = 1'b0;
      out_valid    = 1'b0;
      busy         = 1'b0;
      case (r_state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) w_next_state = RUN;
         end
         RUN: begin
            busy = 1'b1;
            if (w_last) w_next_state = DONE;
         end
         DONE: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            if (out_ready) w_next_state = IDLE;
         end
         default: w_next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ra     <= '0;
         r_rb     <= '0;
         r_rd     <= '0;
         r_d      <= '0;
         r_bout   <= 1'b0;
         r_borrow <= 1'b0;
         r_cnt    <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (in_valid) begin
                  r_ra     <= a;
                  r_rb     <= b;
                  r_borrow <= bin;
                  r_cnt    <= '0;
               end
            end
            RUN: begin
               r_ra     <= r_ra >> 1;
               r_rb     <= r_rb >> 1;
               r_rd     <= w_rd_next;
               r_borrow <= w_bo;
               r_cnt    <= r_cnt + CW'(1);
               // Output registers only change on the final RUN cycle, so DONE holds them.
               if (w_last) begin
`ifdef SERIAL_SUB_SAT_EN
                  r_d <= w_bo ? '0 : w_rd_next;
`else
                  r_d <= w_rd_next;
`endif
                  r_bout <= w_bo;
               end
            end
            default: ;
         endcase
      end
   end

   assign d    = r_d;
   assign bout = r_bout;

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: directed cases, backpressure, mid-run reset,
// ignored input during RUN and randomized operands against an arithmetic model.
module tb_serial_subtractor;

   localparam int W = 8;

   logic         clk       = 1'b0;
   logic         rst_n     = 1'b0;
   logic         in_valid  = 1'b0;
   logic         bin       = 1'b0;
   logic         out_ready = 1'b0;
   logic [W-1:0] a         = '0;
   logic [W-1:0] b         = '0;
   logic         in_ready;
   logic         out_valid;
   logic         bout;
   logic         busy;
   logic [W-1:0] d;

   int n_cmp = 0;
   int n_err = 0;

   serial_subtractor #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .bin       (bin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .d         (d),
      .bout      (bout),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   // {bout, d} from plain signed arithmetic on the operands.
   function automatic logic [W:0] model(input logic [W-1:0] a_i, input logic [W-1:0] b_i,
                                        input logic bin_i);
      int           diff;
      logic         bo;
      logic [W-1:0] dv;
      diff = int'(a_i) - int'(b_i) - int'(bin_i);
      bo   = (diff < 0);
      dv   = W'(diff);
`ifdef SERIAL_SUB_SAT_EN
      if (bo) dv = '0;
`endif
      return {bo, dv};
   endfunction

   task automatic send(input logic [W-1:0] a_i, input logic [W-1:0] b_i, input logic bin_i);
      @(negedge clk);
      a        = a_i;
      b        = b_i;
      bin      = bin_i;
      in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   task automatic wait_valid(output int lat);
      lat = 0;
      while (!out_valid && lat < 64) begin
         @(posedge clk);
         #1 lat++;
      end
   endtask

   task automatic pop();
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
   endtask

   task automatic test_reset();
      #3;
      n_cmp++; if (in_ready !== 1'b1)  begin n_err++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
      n_cmp++; if (busy !== 1'b0)      begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy); end
      n_cmp++; if ({bout, d} !== '0)   begin n_err++; $display("FAIL reset_result: got %b/%h expected 0/00", bout, d); end
      @(negedge clk) rst_n = 1'b1;
      @(negedge clk);
      n_cmp++; if (in_ready !== 1'b1 || busy !== 1'b0) begin
         n_err++; $display("FAIL idle_after_reset: got in_ready=%b busy=%b expected 1/0", in_ready, busy);
      end
   endtask

   task automatic test_directed();
      logic [W-1:0] ta [3];
      logic [W-1:0] tb [3];
      logic         tbi [3];
      logic [W-1:0] ed [3];
      logic         eb [3];
      int           lat;
      ta = '{8'h5A, 8'h00, 8'hFF};
      tb = '{8'h1C, 8'h01, 8'hFF};
      tbi = '{1'b0, 1'b0, 1'b1};
`ifdef SERIAL_SUB_SAT_EN
      ed = '{8'h3E, 8'h00, 8'h00};
`else
      ed = '{8'h3E, 8'hFF, 8'hFF};
`endif
      eb = '{1'b0, 1'b1, 1'b1};
      for (int i = 0; i < 3; i++) begin
         send(ta[i], tb[i], tbi[i]);
         wait_valid(lat);
         n_cmp++; if (lat !== W)      begin n_err++; $display("FAIL dir%0d_latency: got %0d expected %0d", i, lat, W); end
         n_cmp++; if (d !== ed[i])    begin n_err++; $display("FAIL dir%0d_d: got %h expected %h", i, d, ed[i]); end
         n_cmp++; if (bout !== eb[i]) begin n_err++; $display("FAIL dir%0d_bout: got %b expected %b", i, bout, eb[i]); end
         pop();
         n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_err++; $display("FAIL dir%0d_release: got out_valid=%b in_ready=%b expected 0/1", i, out_valid, in_ready);
         end
      end
   endtask

   task automatic test_backpressure();
      logic [W-1:0] ta;
      logic [W-1:0] tb;
      logic         tbi;
      logic [W:0]   exp;
      int           lat;
      ta  = W'($urandom);
      tb  = W'($urandom);
      tbi = 1'($urandom);
      exp = model(ta, tb, tbi);
      send(ta, tb, tbi);
      wait_valid(lat);
      for (int c = 0; c < 5; c++) begin
         n_cmp++; if ({out_valid, in_ready, busy} !== 3'b101) begin
            n_err++; $display("FAIL bp_flags%0d: got valid/ready/busy=%b expected 101", c, {out_valid, in_ready, busy});
         end
         n_cmp++; if ({bout, d} !== exp) begin
            n_err++; $display("FAIL bp_hold%0d: got %b/%h expected %b/%h", c, bout, d, exp[W], exp[W-1:0]);
         end
         @(posedge clk);
         #1;
      end
      pop();
      n_cmp++; if ({out_valid, in_ready, busy} !== 3'b010) begin
         n_err++; $display("FAIL bp_to_idle: got valid/ready/busy=%b expected 010", {out_valid, in_ready, busy});
      end
   endtask

   task automatic test_reset_mid_run();
      int lat;
      send(8'h33, 8'h11, 1'b0);
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      n_cmp++; if ({in_ready, out_valid, busy} !== 3'b100) begin
         n_err++; $display("FAIL midrst_flags: got ready/valid/busy=%b expected 100", {in_ready, out_valid, busy});
      end
      n_cmp++; if ({bout, d} !== '0) begin n_err++; $display("FAIL midrst_result: got %b/%h expected 0/00", bout, d); end
      @(negedge clk) rst_n = 1'b1;
      send(8'h10, 8'h01, 1'b0);
      wait_valid(lat);
      n_cmp++; if ({bout, d} !== {1'b0, 8'h0F}) begin
         n_err++; $display("FAIL midrst_next: got %b/%h expected 0/0f", bout, d);
      end
      pop();
   endtask

   task automatic test_ignore_during_run();
      logic [W-1:0] a1, b1, a2, b2;
      logic         c1, c2;
      int           lat;
      a1 = W'($urandom); b1 = W'($urandom); c1 = 1'($urandom);
      a2 = W'($urandom); b2 = W'($urandom); c2 = 1'($urandom);
      send(a1, b1, c1);
      @(negedge clk);
      a = a2; b = b2; bin = c2; in_valid = 1'b1;
      wait_valid(lat);
      n_cmp++; if ({bout, d} !== model(a1, b1, c1)) begin
         n_err++; $display("FAIL ign_first: got %b/%h expected %h", bout, d, model(a1, b1, c1));
      end
      pop();
      n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL ign_idle: got in_ready=%b expected 1", in_ready); end
      @(posedge clk);
      #1 in_valid = 1'b0;
      n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL ign_accept2: got busy=%b expected 1", busy); end
      wait_valid(lat);
      n_cmp++; if (lat !== W) begin n_err++; $display("FAIL ign_latency: got %0d expected %0d", lat, W); end
      n_cmp++; if ({bout, d} !== model(a2, b2, c2)) begin
         n_err++; $display("FAIL ign_second: got %b/%h expected %h", bout, d, model(a2, b2, c2));
      end
      pop();
   endtask

   task automatic test_random();
      logic [W-1:0] ta, tb;
      logic         tbi;
      int           lat;
      for (int i = 0; i < 40; i++) begin
         ta  = W'($urandom);
         tb  = (i % 4 == 0) ? ta : W'($urandom);
         tbi = 1'($urandom);
         send(ta, tb, tbi);
         wait_valid(lat);
         n_cmp++; if (lat !== W) begin n_err++; $display("FAIL rnd%0d_latency: got %0d expected %0d", i, lat, W); end
         n_cmp++; if ({bout, d} !== model(ta, tb, tbi)) begin
            n_err++; $display("FAIL rnd%0d_result a=%h b=%h bin=%b: got %b/%h expected %h",
                              i, ta, tb, tbi, bout, d, model(ta, tb, tbi));
         end
         repeat ($urandom_range(0, 3)) @(posedge clk);
         #1 pop();
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete within time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_directed();
      test_backpressure();
      test_reset_mid_run();
      test_ignore_during_run();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
